vec3_drive_check: RTL and testbench
===================================

VEC3_DRIVE_CHECK -- requirements
Module: vec3_drive_check

Interface
REQ-001 The block SHALL take parameter HOLD_CYCLES, default 20: clock cycles each vector is held; legal range 2..255.
REQ-002 The block SHALL take parameter EXPECT, default 8'hE8: bit i is the expected l_in for vector index i, where {d,x,a} = i.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request a full 8-vector sweep.
REQ-006 Port d, output, 1 bit: stimulus bit 2, the MSB of the vector index.
REQ-007 Port x, output, 1 bit: stimulus bit 1.
REQ-008 Port a, output, 1 bit: stimulus bit 0, the LSB.
REQ-009 Port l_in, input, 1 bit: response from the combinational DUT; synchronous to clk.
REQ-010 Port busy, output, 1 bit: sweep in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-012 Port pass, output, 1 bit: result of the last completed sweep.
REQ-013 Port err_cnt, output, 4 bits: mismatch count for the current or last sweep, range 0..8.
REQ-014 Port fail_mask, output, 8 bits: bit i set if vector i mismatched.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRIVE and FINISH.
REQ-016 In IDLE, d, x and a SHALL be 0, and busy and done SHALL be 0.
REQ-017 In IDLE, start=1 at an edge SHALL:
- enter DRIVE;
- set idx=0 and hold counter=0;
- clear err_cnt, fail_mask and pass.
REQ-018 In DRIVE, {d,x,a} SHALL equal idx and busy SHALL be 1.
REQ-019 In DRIVE, the hold counter SHALL increment every cycle from 0 to HOLD_CYCLES-1, so each vector is driven for exactly HOLD_CYCLES cycles.
REQ-020 At the edge where counter==HOLD_CYCLES-1, l_in SHALL be sampled and compared with EXPECT[idx].
REQ-021 On a mismatch at that edge:
- err_cnt SHALL increment by 1;
- fail_mask[idx] SHALL be set.
REQ-022 At the sample edge, if idx<7, idx SHALL increment and the counter SHALL return to 0; if idx==7, the FSM SHALL go to FINISH.
REQ-023 The err_cnt increment SHALL include the mismatch of the final (idx=7) sample.
REQ-024 FINISH SHALL last exactly one cycle with:
- done=1, busy=0;
- {d,x,a}=000;
- pass=1 if and only if err_cnt==0.
REQ-025 After FINISH the FSM SHALL return to IDLE.
REQ-026 A sweep SHALL take 8*HOLD_CYCLES cycles in DRIVE, then one FINISH cycle.
REQ-027 start SHALL be ignored in DRIVE and FINISH; it is not queued.
REQ-028 start held high across FINISH SHALL begin a new sweep on the first IDLE cycle.
REQ-029 pass, err_cnt and fail_mask SHALL hold their values in IDLE until the next accepted start.
REQ-030 Outputs d, x, a, busy and done SHALL be driven directly from registers, with no combinational path from l_in or start.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- idx, counter and all outputs to 0, including d, x, a, pass, err_cnt and fail_mask.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-033 After reset release, the first accepted start SHALL begin a sweep from vector 000.

Verification
REQ-034 Reset test: assert rst_n=0 -> all outputs read 0 without a clock edge; hold reset across 3 clocks -> outputs stay 0.
REQ-035 Passing sweep: HOLD_CYCLES=20, EXPECT=8'hE8, l_in driven by a majority-of-(d,x,a) model, pulse start ->
- d,x,a step 000..111, each held 20 cycles;
- done=1 one cycle after 160 DRIVE cycles;
- pass=1, err_cnt=0, fail_mask=8'h00.
REQ-036 Stuck-at-0 DUT: l_in=0 with EXPECT=8'hE8 -> err_cnt=4, fail_mask=8'hE8, pass=0.
REQ-037 Busy/done edges:
- start pulsed at vector 3 -> ignored, sweep unchanged;
- start held high through FINISH -> new sweep starts next cycle with err_cnt cleared.
REQ-038 Mid-sweep reset: rst_n low while idx=5 -> d,x,a=000 and busy=0 at once, no done; a later start -> sweep restarts from 000.
REQ-039 Minimum hold: HOLD_CYCLES=2 with l_in stuck-at-1 -> each vector held exactly 2 cycles, done after 16 DRIVE cycles, fail_mask=8'h17, err_cnt=4.

Source files
------------

// File: rtl/vec3_drive_check.sv
// Drives all eight {d,x,a} vectors into a 3-input combinational block,
// checks each response against EXPECT and reports pass, err_cnt and fail_mask.
module vec3_drive_check #(
  parameter int         HOLD_CYCLES = 20,
  parameter logic [7:0] EXPECT      = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       d,
  output logic       x,
  output logic       a,
  input  logic       l_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_mask
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic       miss;
  logic [3:0] err_inc;
  logic [2:0] idx_nxt;

  assign miss    = (l_in != EXPECT[idx]);
  assign err_inc = err_cnt + {3'd0, miss};
  assign idx_nxt = idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      d         <= 1'b0;
      x         <= 1'b0;
      a         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= '0;
            cnt       <= '0;
            {d, x, a} <= 3'b000;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_mask <= '0;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (miss) begin
              err_cnt        <= err_inc;
              fail_mask[idx] <= 1'b1;
            end
            // The final sample's mismatch must already count toward pass.
            if (idx == 3'd7) begin
              state     <= FINISH;
              idx       <= '0;
              {d, x, a} <= 3'b000;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_inc == 4'd0);
            end else begin
              idx       <= idx_nxt;
              {d, x, a} <= idx_nxt;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec3_drive_check.sv
// Directed bench: two checker instances (hold 20 and hold 2) with
// modelled responses; expected values are hand-derived per vector.
module tb_vec3_drive_check;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic       start0 = 1'b0;
  logic       d0, x0, a0, busy0, done0, pass0, l_in0;
  logic [3:0] err0;
  logic [7:0] mask0;
  int         mode0 = 0;

  logic       start1 = 1'b0;
  logic       d1, x1, a1, busy1, done1, pass1;
  logic       l_in1 = 1'b1;
  logic [3:0] err1;
  logic [7:0] mask1;

  always #5 clk = ~clk;

  always_comb begin
    l_in0 = 1'b0;
    if (mode0 == 0) l_in0 = (d0 & x0) | (d0 & a0) | (x0 & a0);
    else if (mode0 == 2) l_in0 = 1'b1;
  end

  vec3_drive_check #(.HOLD_CYCLES(20), .EXPECT(8'hE8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .d(d0), .x(x0), .a(a0), .l_in(l_in0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_mask(mask0)
  );

  vec3_drive_check #(.HOLD_CYCLES(2), .EXPECT(8'hE8)) u_min (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .d(d1), .x(x1), .a(a1), .l_in(l_in1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_mask(mask1)
  );

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({d0, x0, a0, busy0, done0, pass0, err0, mask0} !== 17'd0) begin
      bad++;
      $display("FAIL reset_async0 got=%h want=0",
               {d0, x0, a0, busy0, done0, pass0, err0, mask0});
    end
    total++;
    if ({d1, x1, a1, busy1, done1, pass1, err1, mask1} !== 17'd0) begin
      bad++;
      $display("FAIL reset_async1 got=%h want=0",
               {d1, x1, a1, busy1, done1, pass1, err1, mask1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({d0, x0, a0, busy0, done0, pass0, err0, mask0,
           d1, x1, a1, busy1, done1, pass1, err1, mask1} !== 34'd0) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got nonzero outputs", i);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_sweep();
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 20; c++) begin
        total++;
        if ({d0, x0, a0} !== 3'(v) || busy0 !== 1'b1 || done0 !== 1'b0) begin
          bad++;
          $display("FAIL pass_drive v=%0d c=%0d got dxa=%b busy=%b done=%b want dxa=%0d busy=1 done=0",
                   v, c, {d0, x0, a0}, busy0, done0, v);
        end
        @(negedge clk);
      end
    end
    total++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || {d0, x0, a0} !== 3'b000) begin
      bad++;
      $display("FAIL pass_finish got done=%b busy=%b dxa=%b want 1 0 000",
               done0, busy0, {d0, x0, a0});
    end
    total++;
    if (pass0 !== 1'b1 || err0 !== 4'd0 || mask0 !== 8'h00) begin
      bad++;
      $display("FAIL pass_result got pass=%b err=%0d mask=%h want 1 0 00",
               pass0, err0, mask0);
    end
    @(negedge clk);
    total++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || pass0 !== 1'b1) begin
      bad++;
      $display("FAIL pass_idle got done=%b busy=%b pass=%b want 0 0 1",
               done0, busy0, pass0);
    end
  endtask

  task automatic test_stuck0();
    int n;
    mode0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 160) begin
      bad++;
      $display("FAIL stuck0_latency got=%0d want=160", n);
    end
    total++;
    if (err0 !== 4'd4 || mask0 !== 8'hE8 || pass0 !== 1'b0) begin
      bad++;
      $display("FAIL stuck0_result got err=%0d mask=%h pass=%b want 4 e8 0",
               err0, mask0, pass0);
    end
    repeat (5) @(negedge clk);
    total++;
    if (err0 !== 4'd4 || mask0 !== 8'hE8 || pass0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL stuck0_hold got err=%0d mask=%h pass=%b busy=%b want 4 e8 0 0",
               err0, mask0, pass0, busy0);
    end
  endtask

  task automatic test_busy_done();
    int n;
    mode0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (65) @(negedge clk);
    total++;
    if ({d0, x0, a0} !== 3'd3) begin
      bad++;
      $display("FAIL bd_at_vec3 got dxa=%b want 011", {d0, x0, a0});
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    total++;
    if ({d0, x0, a0} !== 3'd3 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL bd_ignore got dxa=%b busy=%b want 011 1", {d0, x0, a0}, busy0);
    end
    n = 66;
    while (done0 !== 1'b1 && n < 400) begin
      if (n == 150) start0 = 1'b1;
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 160) begin
      bad++;
      $display("FAIL bd_latency got=%0d want=160", n);
    end
    total++;
    if (err0 !== 4'd4 || mask0 !== 8'hE8) begin
      bad++;
      $display("FAIL bd_result got err=%0d mask=%h want 4 e8", err0, mask0);
    end
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 4'd4) begin
      bad++;
      $display("FAIL bd_idle_gap got busy=%b done=%b err=%0d want 0 0 4",
               busy0, done0, err0);
    end
    @(negedge clk);
    start0 = 1'b0;
    total++;
    if (busy0 !== 1'b1 || {d0, x0, a0} !== 3'b000 || err0 !== 4'd0 ||
        mask0 !== 8'h00 || pass0 !== 1'b0) begin
      bad++;
      $display("FAIL bd_restart got busy=%b dxa=%b err=%0d mask=%h pass=%b want 1 000 0 00 0",
               busy0, {d0, x0, a0}, err0, mask0, pass0);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    repeat (103) @(negedge clk);
    total++;
    if ({d0, x0, a0} !== 3'd5 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL mr_at_vec5 got dxa=%b busy=%b want 101 1", {d0, x0, a0}, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({d0, x0, a0} !== 3'b000 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        err0 !== 4'd0 || mask0 !== 8'h00) begin
      bad++;
      $display("FAIL mr_async got dxa=%b busy=%b done=%b err=%0d mask=%h want all 0",
               {d0, x0, a0}, busy0, done0, err0, mask0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mr_no_done got activity=1 want 0");
    end
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    total++;
    if ({d0, x0, a0} !== 3'b000 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL mr_restart got dxa=%b busy=%b want 000 1", {d0, x0, a0}, busy0);
    end
    repeat (20) @(negedge clk);
    total++;
    if ({d0, x0, a0} !== 3'b001) begin
      bad++;
      $display("FAIL mr_second_vec got dxa=%b want 001", {d0, x0, a0});
    end
  endtask

  task automatic test_min_hold();
    l_in1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 2; c++) begin
        total++;
        if ({d1, x1, a1} !== 3'(v) || busy1 !== 1'b1 || done1 !== 1'b0) begin
          bad++;
          $display("FAIL min_drive v=%0d c=%0d got dxa=%b busy=%b done=%b want dxa=%0d 1 0",
                   v, c, {d1, x1, a1}, busy1, done1, v);
        end
        @(negedge clk);
      end
    end
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL min_finish got done=%b busy=%b want 1 0", done1, busy1);
    end
    total++;
    if (mask1 !== 8'h17 || err1 !== 4'd4 || pass1 !== 1'b0) begin
      bad++;
      $display("FAIL min_result got mask=%h err=%0d pass=%b want 17 4 0",
               mask1, err1, pass1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL min_done_pulse got done=%b want 0", done1);
    end
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_stuck0();
    test_busy_done();
    test_mid_reset();
    test_min_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
